// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int          PC_W             = 32;
    localparam int          ID_DATA_W        = 62;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef logic [PC_W-1:0] pc_t;

    // Sequential successor of a word-aligned PC.
    function automatic pc_t pc_next(input pc_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fifo2.sv
// Small circular FIFO used for fetch tags and for parked responses.
// Storage is not reset; only pointers and occupancy are.
module if_fifo2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Entry storage: written on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; clear empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: keeps up to MAX_OUTST fetches in flight,
// fills IF/ID with {PC+4, instr}, and follows decode redirects with or
// without a branch delay slot.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jpc_avail,
    input  logic [31:0]          jpc,
    input  logic                 nodslot,
    input  logic                 stall,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [31:0]          imem_rdata,
    output logic [ID_DATA_W-1:0] id_data,
    output logic                 id_valid
);

    localparam int CW = $clog2(MAX_OUTST+1);

    // fetch_pc: next address to request. deliver_pc: next PC owed to IF/ID.
    // accept_pc: PC of the next response worth keeping (runs ahead of
    // deliver_pc by whatever is parked in the response buffer).
    pc_t           fetch_pc;
    pc_t           deliver_pc;
    pc_t           accept_pc;
    pc_t           target;
    logic          redir_pend;   // deliver side jumps to target after the delay slot
    logic          acc_jump;     // accept side jumps to target after keeping the delay slot
    logic          fetch_redir;  // fetch side jumps to target on the next grant

    logic [CW-1:0] tag_cnt;
    logic [CW-1:0] buf_cnt;
    pc_t           tag_head;
    logic [31:0]   buf_head;
    logic [CW:0]   outst;

    logic          granted;
    logic          redir_nods;
    logic          redir_ds;
    logic          keep;
    logic          buf_empty;
    logic          load;
    logic [31:0]   load_instr;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_clear;
    logic [29:0]   pcp1_word;

    assign outst      = {1'b0, tag_cnt} + {1'b0, buf_cnt};
    assign imem_req   = rst && (outst < (CW+1)'(MAX_OUTST));
    assign imem_addr  = fetch_pc;
    assign granted    = imem_req && imem_gnt;

    assign redir_nods = jpc_avail && !stall && nodslot;
    assign redir_ds   = jpc_avail && !stall && !nodslot;

    assign keep       = imem_rvalid && (tag_head == accept_pc);
    assign buf_empty  = (buf_cnt == '0);
    assign load       = !stall && (!buf_empty || keep);
    assign load_instr = buf_empty ? imem_rdata : buf_head;

    // A delay-slot redirect that delivers the slot this cycle drops anything
    // already kept beyond it; an exception redirect drops everything.
    assign buf_clear  = redir_nods || (redir_ds && load);
    assign buf_push   = keep && !(load && buf_empty) && !buf_clear;
    assign buf_pop    = load && !buf_empty;

    assign pcp1_word  = deliver_pc[31:2] + 30'd1;

    if_fifo2 #(.WIDTH(PC_W), .DEPTH(MAX_OUTST)) u_tags (
        .clk       (clk),
        .rst       (rst),
        .push      (granted),
        .push_data (fetch_pc),
        .pop       (imem_rvalid),
        .clear     (1'b0),
        .head      (tag_head),
        .count     (tag_cnt)
    );

    if_fifo2 #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_rbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (imem_rdata),
        .pop       (buf_pop),
        .clear     (buf_clear),
        .head      (buf_head),
        .count     (buf_cnt)
    );

    // Fetch address: a request already on the bus keeps its address until granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            fetch_redir <= 1'b0;
        end else if (redir_nods) begin
            if (imem_req && !imem_gnt) begin
                fetch_redir <= 1'b1;
            end else begin
                fetch_pc    <= jpc;
                fetch_redir <= 1'b0;
            end
        end else if (redir_ds) begin
            if (granted) begin
                fetch_pc    <= jpc;
                fetch_redir <= 1'b0;
            end else if (imem_req || (fetch_pc == deliver_pc)) begin
                fetch_redir <= 1'b1;
            end else begin
                fetch_pc <= jpc;
            end
        end else if (granted) begin
            fetch_pc    <= fetch_redir ? target : pc_next(fetch_pc);
            fetch_redir <= 1'b0;
        end
    end

    // Accept/deliver bookkeeping: normal progress first, then redirect overrides.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deliver_pc <= RESET_PC;
            accept_pc  <= RESET_PC;
            target     <= RESET_PC;
            redir_pend <= 1'b0;
            acc_jump   <= 1'b0;
        end else begin
            if (keep) begin
                accept_pc <= acc_jump ? target : pc_next(accept_pc);
                acc_jump  <= 1'b0;
            end
            if (load) begin
                deliver_pc <= redir_pend ? target : pc_next(deliver_pc);
                redir_pend <= 1'b0;
            end
            if (redir_nods) begin
                deliver_pc <= jpc;
                accept_pc  <= jpc;
                target     <= jpc;
                redir_pend <= 1'b0;
                acc_jump   <= 1'b0;
            end else if (redir_ds) begin
                target <= jpc;
                if (load) begin
                    deliver_pc <= jpc;
                    accept_pc  <= jpc;
                    redir_pend <= 1'b0;
                    acc_jump   <= 1'b0;
                end else begin
                    redir_pend <= 1'b1;
                    acc_jump   <= 1'b1;
                end
            end
        end
    end

    // IF/ID register: reload whenever decode is not stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid <= 1'b0;
            id_data  <= '0;
        end else if (redir_nods) begin
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_valid <= load;
            if (load) begin
                id_data <= {pcp1_word, load_instr};
            end
        end
    end

endmodule
